// File: rtl/regfile_param_pkg.sv
// Shared definitions for the parametrised register file: default data width
// and the clear-sequencer state encoding.
package regfile_param_pkg;

    localparam int D_WIDTH = 8;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: range check, optional hardwired-zero r0 and
// optional same-cycle write bypass.
module regfile_read_port
    import regfile_param_pkg::*;
#(
    parameter int D_W      = D_WIDTH,
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int BYPASS   = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic [NUM_REGS-1:0][D_W-1:0] regs,
    input  logic [AW-1:0]                read_addr,
    input  logic                         write_accept,
    input  logic [AW-1:0]                write_addr,
    input  logic [D_W-1:0]               write_data,
    output logic [D_W-1:0]               read_data
);

    logic in_range;

    assign in_range = (int'(read_addr) < NUM_REGS);

    // write_accept already excludes dropped writes, so bypass needs no extra qualification.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        read_data = '0;
        if (in_range) begin
            read_data = regs[read_addr];
        end
        if ((R0_ZERO != 0) && (read_addr == '0)) begin
            read_data = '0;
        end
        if ((BYPASS != 0) && write_accept && (write_addr == read_addr)) begin
            read_data = write_data;
        end
    end

endmodule

// File: rtl/regfile_param.sv
// Single-write, dual-read register file with bypass, optional zero r0 and a
// one-register-per-cycle bulk clear sequencer with busy/clear_done handshake.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int D_W      = D_WIDTH,
    parameter int NUM_REGS = 8,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int BYPASS   = 1,
    parameter int R0_ZERO  = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           write_en,
    input  logic [AW-1:0]  write_addr,
    input  logic [D_W-1:0] write_data,
    input  logic [AW-1:0]  read_addr_1,
    input  logic [AW-1:0]  read_addr_2,
    output logic [D_W-1:0] read_data_1,
    output logic [D_W-1:0] read_data_2,
    input  logic           clear_req,
    output logic           busy,
    output logic           clear_done
);

    localparam logic [AW-1:0] LAST_PTR = AW'(NUM_REGS - 1);

    logic [NUM_REGS-1:0][D_W-1:0] regs;
    rf_state_t                    state, state_d;
    logic [AW-1:0]                ptr, ptr_d;
    logic                         busy_d, clear_done_d;
    logic                         write_in_range, write_to_r0, write_accept;

    assign write_in_range = (int'(write_addr) < NUM_REGS);
    assign write_to_r0    = (R0_ZERO != 0) && (write_addr == '0);
    assign write_accept   = write_en && (state == RF_IDLE) && write_in_range && !write_to_r0;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        case (state)
            RF_IDLE: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
            RF_CLEAR: begin
                if (ptr == LAST_PTR) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr + AW'(1);
                end
            end
            default: state_d = RF_IDLE;
        endcase
        // Registered flags are computed from the next state so they line up with it.
        busy_d       = (state_d == RF_CLEAR);
        clear_done_d = (state_d == RF_CLEAR) && (ptr_d == LAST_PTR);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            // NOTE: the array is plain flops and is deliberately cleared by reset; it must never map to RAM.
            regs       <= '0;
            state      <= RF_IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            busy       <= busy_d;
            clear_done <= clear_done_d;
            if (state == RF_CLEAR) begin
                regs[ptr] <= '0;
            end else if (write_accept) begin
                regs[write_addr] <= write_data;
            end
        end
    end

    regfile_read_port #(
        .D_W(D_W), .NUM_REGS(NUM_REGS), .AW(AW), .BYPASS(BYPASS), .R0_ZERO(R0_ZERO)
    ) u_read_port_1 (
        .regs        (regs),
        .read_addr   (read_addr_1),
        .write_accept(write_accept),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_data   (read_data_1)
    );

    regfile_read_port #(
        .D_W(D_W), .NUM_REGS(NUM_REGS), .AW(AW), .BYPASS(BYPASS), .R0_ZERO(R0_ZERO)
    ) u_read_port_2 (
        .regs        (regs),
        .read_addr   (read_addr_2),
        .write_accept(write_accept),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .read_data   (read_data_2)
    );

endmodule
